// File: rtl/bus_arb_pkg.sv
// Shared constants and enums for the N-master bus arbiter.
package bus_arb_pkg;

    // Grants, requests and locks are all active-low on the pins
    localparam logic ENABLE  = 1'b0;
    localparam logic DISABLE = 1'b1;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        BUSY = 2'd1,
        LOCK = 2'd2
    } arb_state_e;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/bus_arb_pick.sv
// Winner search: first candidate at offsets 0..NUM_M-1 from start, wrapping.
module bus_arb_pick #(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned IW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    start,
    input  logic [NUM_M-1:0] excl,
    output logic [IW-1:0]    winner,
    output logic             found
);

    logic [NUM_M-1:0] cand;

    assign cand = req & ~excl;

    // Scan candidates in circular order starting at start; first hit wins
    always_comb begin
        logic [IW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned off = 0; off < NUM_M; off++) begin
            idx = IW'((32'(start) + off) % NUM_M);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed-priority or round-robin, sticky grants,
// lock support and tenure limit under contention. Grants are registered.
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_M      = 4,
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned IW         = $clog2(NUM_M)
) (
    input  logic             bus_clk,
    input  logic             bus_rst,
    input  logic             arb_mode,
    input  logic [NUM_M-1:0] m_reqn,
    input  logic [NUM_M-1:0] m_lockn,
    output logic [NUM_M-1:0] m_grntn,
    output logic [IW-1:0]    bus_owner,
    output logic             tenure_exp
);

    localparam int unsigned TW = (MAX_TENURE < 1) ? 1 : $clog2(MAX_TENURE + 1);
    localparam logic [TW-1:0] TEN_LAST = TW'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);
    localparam logic [TW-1:0] TEN_MAX  = TW'(MAX_TENURE);
    localparam logic          TEN_ON   = (MAX_TENURE != 0);

    arb_state_e       state, state_d;
    logic [IW-1:0]    owner_d;
    logic [TW-1:0]    tenure, tenure_d;
    logic             exp_d;
    logic [NUM_M-1:0] grntn_d;

    logic [NUM_M-1:0] req, lock, own_mask, pick_excl;
    logic             own_req, own_lock, win_lock, found;
    logic [IW-1:0]    pick_start, winner;

    assign req      = ~m_reqn;
    assign lock     = ~m_lockn;
    assign own_mask = NUM_M'(1) << bus_owner;
    assign own_req  = |(req & own_mask);
    assign own_lock = |(lock & own_mask);
    assign win_lock = |(lock & (NUM_M'(1) << winner));

    // Round-robin searches from owner+1; fixed priority always from index 0
    assign pick_start = (arb_mode == MODE_RR)
                      ? ((bus_owner == IW'(NUM_M - 1)) ? '0 : bus_owner + IW'(1))
                      : '0;
    // A parked owner competes (last in RR order); otherwise it is excluded
    assign pick_excl  = (state == PARK) ? '0 : own_mask;

    bus_arb_pick #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .start  (pick_start),
        .excl   (pick_excl),
        .winner (winner),
        .found  (found)
    );

    // Next-state, ownership, tenure and grant decode
    always_comb begin
        state_d  = state;
        owner_d  = bus_owner;
        tenure_d = tenure;
        exp_d    = 1'b0;

        case (state)
            PARK: begin
                if (found) begin
                    owner_d  = winner;
                    state_d  = win_lock ? LOCK : BUSY;
                    tenure_d = '0;
                end
            end
            BUSY: begin
                if (!own_req) begin
                    tenure_d = '0;
                    if (found) begin
                        owner_d = winner;
                        state_d = win_lock ? LOCK : BUSY;
                    end else begin
                        state_d = PARK;
                    end
                end else if (own_lock) begin
                    state_d  = LOCK;
                    tenure_d = '0;
                end else if (TEN_ON && found) begin
                    if (tenure == TEN_LAST) begin
                        owner_d  = winner;
                        state_d  = win_lock ? LOCK : BUSY;
                        tenure_d = '0;
                        exp_d    = 1'b1;
                    end else if (tenure != TEN_MAX) begin
                        tenure_d = tenure + TW'(1);
                    end
                end
            end
            LOCK: begin
                if (!own_req) begin
                    tenure_d = '0;
                    if (found) begin
                        owner_d = winner;
                        state_d = win_lock ? LOCK : BUSY;
                    end else begin
                        state_d = PARK;
                    end
                end else if (!own_lock) begin
                    state_d  = BUSY;
                    tenure_d = '0;
                end
            end
            default: begin
                state_d  = PARK;
                tenure_d = '0;
            end
        endcase

        grntn_d          = {NUM_M{DISABLE}};
        grntn_d[owner_d] = ENABLE;
    end

    // State, owner and registered outputs; reset overrides every transition
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state      <= PARK;
            bus_owner  <= '0;
            tenure     <= '0;
            tenure_exp <= 1'b0;
            m_grntn    <= ~NUM_M'(1);
        end else begin
            state      <= state_d;
            bus_owner  <= owner_d;
            tenure     <= tenure_d;
            tenure_exp <= exp_d;
            m_grntn    <= grntn_d;
        end
    end

endmodule
